bit16_priority_encoder: RTL and testbench

BIT16_PRIORITY_ENCODER -- requirements
Module: bit16_priority_encoder

---
 rtl/bit16_priority_encoder_if.sv | 25 ++
 rtl/bit16_priority_encoder.sv | 108 ++++++++++
 tb/tb_bit16_priority_encoder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bit16_priority_encoder_if.sv
// Request/issue bundle between a requester and the 16-source priority encoder.
// Latency: n/a (wires only).
// Backpressure: the consumer holds off issue by withholding out_ack while out_valid is high.
interface bit16_priority_encoder_if;
   logic [15:0] req;
   logic [15:0] mask;
   logic        act;
   logic        out_ack;
   logic        out_valid;
   logic [3:0]  out_code;
   logic [15:0] pending;
   logic        multi;

   // Requester side: drives requests, enables and the acknowledge.
   modport master (
      output req, mask, act, out_ack,
      input  out_valid, out_code, pending, multi
   );

   // Encoder side: consumes requests, presents the registered code.
   modport slave (
      input  req, mask, act, out_ack,
      output out_valid, out_code, pending, multi
   );
endinterface

// File: rtl/bit16_priority_encoder.sv
// Sticky 16-source priority encoder: lowest eligible pending index is presented until acked.
// Latency: req before edge n -> pending after n -> out_valid after n+1; one idle bubble between codes.
// Backpressure: a presented code is held stable until out_ack; new requests accumulate in pending.
module bit16_priority_encoder (
   input  logic                           clk,
   input  logic                           rst_n,
   bit16_priority_encoder_if.slave        io_enc
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_pending;
   logic [3:0]  r_code;
   logic        r_multi;

   logic [15:0] w_elig;
   logic [3:0]  w_win_code;
   logic        w_win_multi;
   logic        w_issue;
   logic        w_ack;
   logic [15:0] w_clr;
   logic [15:0] w_pending_nxt;

   assign w_elig = r_pending & io_enc.mask;

   // Lowest set eligible index wins; multi flags more than one eligible bit.
   always_comb begin
      w_win_code = 4'h0;
      for (int i = 15; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_win_code = 4'(i);
         end
      end
      w_win_multi = |(w_elig & (w_elig - 16'd1));
   end

   // Next-state: issue from IDLE only, return to IDLE on ack; pending clear decided here too.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_ack       = 1'b0;
      w_clr       = 16'h0000;
      case (r_state)
         IDLE: begin
            if (io_enc.act && (w_elig != 16'h0000)) begin
               w_issue     = 1'b1;
               w_state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (io_enc.out_ack) begin
               w_ack       = 1'b1;
               w_clr       = 16'h0001 << r_code;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      // A request on the acked line at the same edge wins over the clear.
      w_pending_nxt = (r_pending & ~w_clr) | io_enc.req;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Sticky pending capture every edge, independent of act, mask or state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= 16'h0000;
      end else begin
         r_pending <= w_pending_nxt;
      end
   end

   // Code and multi load only on issue; they hold across PRESENT and IDLE otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_code  <= 4'h0;
         r_multi <= 1'b0;
      end else if (w_issue) begin
         r_code  <= w_win_code;
         r_multi <= w_win_multi;
      end
   end

   assign io_enc.out_valid = (r_state == PRESENT);
   assign io_enc.out_code  = r_code;
   assign io_enc.multi     = r_multi;
   assign io_enc.pending   = r_pending;

   // w_ack is kept for readability of the PRESENT exit; fold it into nothing else.
   logic w_unused;
   assign w_unused = w_ack;

endmodule

// File: tb/tb_bit16_priority_encoder.sv
module tb_bit16_priority_encoder;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   bit16_priority_encoder_if bus ();

   bit16_priority_encoder dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_enc (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference ----------------
   bit [15:0] m_pend;
   bit        m_busy;
   bit [3:0]  m_code;
   bit        m_multi;

   function automatic int lowest_index(input bit [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return i;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit [15:0] old_pend;
      bit [15:0] elig;
      bit [15:0] keep;
      if (!rst_n) begin
         m_pend  = '0;
         m_busy  = 0;
         m_code  = 0;
         m_multi = 0;
      end else begin
         old_pend = m_pend;
         elig     = old_pend & bus.mask;
         keep     = 16'hFFFF;
         if (m_busy) begin
            if (bus.out_ack) begin
               keep[m_code] = 1'b0;
               m_busy       = 0;
            end
         end else if (bus.act && elig != 0) begin
            m_code  = 4'(lowest_index(elig));
            m_multi = ($countones(elig) > 1);
            m_busy  = 1;
         end
         m_pend = (old_pend & keep) | bus.req;
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [15:0] act_v, input logic [15:0] exp_v);
      n_vec++;
      if (act_v !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act_v, exp_v, $time);
      end
   endtask

   task automatic compare();
      chk("out_valid", 16'(bus.out_valid), 16'(m_busy));
      chk("pending",   bus.pending,        m_pend);
      if (m_busy) begin
         chk("out_code", 16'(bus.out_code), 16'(m_code));
         chk("multi",    16'(bus.multi),    16'(m_multi));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      compare();
   endtask

   task automatic set_in(input logic [15:0] r, input logic [15:0] m, input logic a, input logic k);
      bus.req     = r;
      bus.mask    = m;
      bus.act     = a;
      bus.out_ack = k;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      set_in(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

      // Reset holds everything clear despite requests.
      repeat (3) begin
         tick();
         chk("rst_valid", 16'(bus.out_valid), 16'h0);
         chk("rst_pend",  bus.pending,        16'h0000);
         chk("rst_code",  16'(bus.out_code),  16'h0);
         chk("rst_multi", 16'(bus.multi),     16'h0);
      end
      set_in(16'h0000, 16'hFFFF, 1'b1, 1'b0);
      rst_n = 1'b1;
      tick();

      // Single request on source 15.
      set_in(16'h8000, 16'hFFFF, 1'b1, 1'b0);
      tick();
      chk("single_pend", bus.pending, 16'h8000);
      chk("single_not_yet", 16'(bus.out_valid), 16'h0);
      set_in(16'h0000, 16'hFFFF, 1'b1, 1'b0);
      tick();
      chk("single_valid", 16'(bus.out_valid), 16'h1);
      chk("single_code",  16'(bus.out_code),  16'hF);
      chk("single_multi", 16'(bus.multi),     16'h0);
      chk("model_code15", 16'(m_code),        16'hF);
      bus.out_ack = 1'b1;
      tick();
      bus.out_ack = 1'b0;
      chk("single_ack_valid", 16'(bus.out_valid), 16'h0);
      chk("single_ack_pend",  bus.pending,        16'h0000);

      // Priority order 2 then 5 with one bubble.
      set_in(16'h0024, 16'hFFFF, 1'b1, 1'b0);
      tick();
      bus.req = 16'h0000;
      tick();
      chk("prio_code2",  16'(bus.out_code), 16'h2);
      chk("prio_multi1", 16'(bus.multi),    16'h1);
      chk("model_multi", 16'(m_multi),      16'h1);
      bus.out_ack = 1'b1;
      tick();
      bus.out_ack = 1'b0;
      chk("prio_bubble", 16'(bus.out_valid), 16'h0);
      chk("prio_pend20", bus.pending,        16'h0020);
      tick();
      chk("prio_code5",  16'(bus.out_code), 16'h5);
      chk("prio_multi0", 16'(bus.multi),    16'h0);
      bus.out_ack = 1'b1;
      tick();
      bus.out_ack = 1'b0;
      chk("prio_empty", bus.pending, 16'h0000);

      // Masking and act gating; ack while idle is ignored.
      set_in(16'h0024, 16'hFFFB, 1'b0, 1'b0);
      tick();
      set_in(16'h0000, 16'hFFFB, 1'b0, 1'b1);
      repeat (3) tick();
      chk("act0_noissue", 16'(bus.out_valid), 16'h0);
      chk("act0_pend",    bus.pending,        16'h0024);
      set_in(16'h0000, 16'hFFFB, 1'b1, 1'b0);
      tick();
      chk("mask_code5",  16'(bus.out_code), 16'h5);
      chk("mask_multi0", 16'(bus.multi),    16'h0);
      bus.out_ack = 1'b1;
      tick();
      chk("mask_keep2", bus.pending, 16'h0004);
      set_in(16'h0000, 16'hFFFF, 1'b1, 1'b0);
      tick();
      chk("unmask_code2", 16'(bus.out_code), 16'h2);
      bus.out_ack = 1'b1;
      tick();
      bus.out_ack = 1'b0;

      // Simultaneous ack and re-request on source 3.
      bus.req = 16'h0008;
      tick();
      bus.req = 16'h0000;
      tick();
      chk("rereq_code3", 16'(bus.out_code), 16'h3);
      set_in(16'h0008, 16'hFFFF, 1'b1, 1'b1);
      tick();
      chk("rereq_pend", bus.pending, 16'h0008);
      set_in(16'h0000, 16'hFFFF, 1'b1, 1'b0);
      tick();
      chk("rereq_again", 16'(bus.out_code), 16'h3);
      chk("rereq_valid", 16'(bus.out_valid), 16'h1);
      bus.out_ack = 1'b1;
      tick();
      bus.out_ack = 1'b0;

      // Hold stability, then async reset mid-present.
      bus.req = 16'h0080;
      tick();
      bus.req = 16'h0000;
      tick();
      set_in(16'h0001, 16'hFF7F, 1'b1, 1'b0);
      repeat (2) tick();
      chk("hold_code7",  16'(bus.out_code),  16'h7);
      chk("hold_valid",  16'(bus.out_valid), 16'h1);
      set_in(16'h0000, 16'hFFFF, 1'b1, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 16'(bus.out_valid), 16'h0);
      chk("arst_pend",  bus.pending,        16'h0000);
      @(negedge clk);
      compare();
      rst_n = 1'b1;
      tick();

      // Randomised traffic.
      for (int c = 0; c < 3000; c++) begin
         logic [15:0] r;
         r = '0;
         if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 15)] = 1'b1;
         if ($urandom_range(0, 9) == 0) r = 16'($urandom);
         bus.req     = r;
         bus.mask    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
         bus.act     = ($urandom_range(0, 4) != 0);
         bus.out_ack = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
